// File: rtl/spi_slave_shifter_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_shifter_pkg
// Shared constants for the SPI slave shift engine: default word width, default
// MISO fill word and the FSM state encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_slave_shifter_pkg;

  localparam int          SPI_WIDTH_DEFAULT   = 8;
  localparam logic [31:0] SPI_TX_FILL_DEFAULT = 32'hFFFF_FFFF;

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_slave_shifter_edge_detect.sv
// -----------------------------------------------------------------------------
// spi_slave_shifter_edge_detect
// One-flop delay of an already-synchronised signal with combinational rise and
// fall pulses derived from the current and delayed values.
// Ports:
//   clk   in  1  system clock, posedge
//   rst   in  1  synchronous active-high reset (delay flop cleared to 0)
//   sig   in  1  synchronised input signal
//   rise  out 1  sig is 1 now and was 0 last cycle
//   fall  out 1  sig is 0 now and was 1 last cycle
// -----------------------------------------------------------------------------
module spi_slave_shifter_edge_detect
  import spi_slave_shifter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;

  // Clearing the delay flop to 0 means a chip select that is already low
  // when reset releases never looks like a falling edge, so a frame
  // interrupted by reset is not resumed half-way through.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig;
    end
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/spi_slave_shifter.sv
// -----------------------------------------------------------------------------
// spi_slave_shifter
// SPI mode-0 slave shift engine running entirely in the clk domain. It takes
// synchronised SCLK/MOSI/CS_N, assembles WIDTH-bit MOSI words (one rx_valid
// pulse each) and serialises user tx words onto MISO.
// Ports:
//   clk          in  1      system clock, posedge
//   rst          in  1      synchronous active-high reset
//   sclk_sync    in  1      synchronised SPI clock
//   mosi_sync    in  1      synchronised MOSI
//   cs_n_sync    in  1      synchronised chip select, active low
//   miso         out 1      serial data out (0 outside a frame)
//   cs_active    out 1      high while a frame is in progress
//   rx_data      out WIDTH  last completed received word
//   rx_valid     out 1      pulse: rx_data updated this cycle
//   tx_data      in  WIDTH  next word to transmit
//   tx_valid     in  1      tx_data is valid
//   tx_ready     out 1      pulse: tx word latched this cycle
//   tx_underrun  out 1      pulse: latched with tx_valid low, TX_FILL sent
//   frame_abort  out 1      pulse: CS released mid-word
// -----------------------------------------------------------------------------
module spi_slave_shifter
  import spi_slave_shifter_pkg::*;
#(
  parameter int               WIDTH     = SPI_WIDTH_DEFAULT,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] TX_FILL   = SPI_TX_FILL_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_sync,
  input  logic             mosi_sync,
  input  logic             cs_n_sync,
  output logic             miso,
  output logic             cs_active,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_abort
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic             sclk_rise;
  logic             sclk_fall;
  logic             cs_rise;
  logic             cs_fall;

  logic [0:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic             word_done;

  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_shifted;
  logic             tx_load;

  spi_slave_shifter_edge_detect u_sclk_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_slave_shifter_edge_detect u_cs_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (cs_n_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign rx_next    = MSB_FIRST ? {rx_shift[WIDTH-2:0], mosi_sync}
                                : {mosi_sync, rx_shift[WIDTH-1:1]};
  assign tx_shifted = MSB_FIRST ? {tx_shift[WIDTH-2:0], 1'b0}
                                : {1'b0, tx_shift[WIDTH-1:1]};

  // A tx word is loaded at the start of a frame and on the first SCLK fall
  // after each completed word. A simultaneous cs_rise cancels the fall-side
  // load because the frame is ending. Gated by rst so the handshake pulses
  // stay low while the block is being reset.
  assign tx_load = ~rst & (((state == ST_IDLE) & cs_fall) |
                           ((state == ST_ACTIVE) & ~cs_rise & sclk_fall & word_done));

  assign tx_ready    = tx_load;
  assign tx_underrun = tx_load & ~tx_valid;

  assign cs_active = (state == ST_ACTIVE);
  assign miso      = cs_active & (MSB_FIRST ? tx_shift[WIDTH-1] : tx_shift[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      word_done   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;

      if (tx_load) begin
        tx_shift <= tx_valid ? tx_data : TX_FILL;
      end

      if (state == ST_IDLE) begin
        if (cs_fall) begin
          state     <= ST_ACTIVE;
          bit_cnt   <= '0;
          rx_shift  <= '0;
          word_done <= 1'b0;
        end
      end else begin
        // cs_rise takes priority over any SCLK edge seen in the same cycle,
        // so a word finishing exactly as CS releases is dropped.
        if (cs_rise) begin
          state       <= ST_IDLE;
          frame_abort <= (bit_cnt != '0);
          bit_cnt     <= '0;
          word_done   <= 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              rx_data   <= rx_next;
              rx_valid  <= 1'b1;
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          // The fall after a completed word is the load point (handled by
          // tx_load above) instead of a shift.
          if (sclk_fall) begin
            if (word_done) begin
              word_done <= 1'b0;
            end else begin
              tx_shift <= tx_shifted;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_shifter
// Directed bench for spi_slave_shifter (WIDTH=8, MSB first, 50 MHz clk with a
// 5 MHz SCLK: five clk cycles per SCLK phase). Inputs change 1 ns after a
// clk posedge; pulse outputs are counted on the clk negedge.
// -----------------------------------------------------------------------------
module tb_spi_slave_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_sync;
  logic       mosi_sync;
  logic       cs_n_sync;
  logic       miso;
  logic       cs_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic       frame_abort;

  int total = 0;
  int bad   = 0;

  int rx_cnt       = 0;
  int ready_cnt    = 0;
  int underrun_cnt = 0;
  int abort_cnt    = 0;
  logic [7:0] last_rx = 8'h00;

  int rx_base;
  int ready_base;
  int underrun_base;
  int abort_base;
  logic [7:0] miso_word;
  logic [7:0] words [3];

  spi_slave_shifter #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1),
    .TX_FILL   (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk_sync   (sclk_sync),
    .mosi_sync   (mosi_sync),
    .cs_n_sync   (cs_n_sync),
    .miso        (miso),
    .cs_active   (cs_active),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort)
  );

  always #10 clk = ~clk;

  // Pulse counters sampled mid-cycle; tests compare deltas of these.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      last_rx <= rx_data;
    end
    if (tx_ready)    ready_cnt    <= ready_cnt + 1;
    if (tx_underrun) underrun_cnt <= underrun_cnt + 1;
    if (frame_abort) abort_cnt    <= abort_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic snapshot();
    rx_base       = rx_cnt;
    ready_base    = ready_cnt;
    underrun_base = underrun_cnt;
    abort_base    = abort_cnt;
  endtask

  // Shifts the top nbits of w out on MOSI, MSB first, capturing MISO at
  // each SCLK rise as a mode-0 master would.
  task automatic applyStimulus(input logic [7:0] w, input int nbits,
                               output logic [7:0] m);
    m = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi_sync = w[7-i];
      tick(5);
      sclk_sync = 1'b1;
      m[7-i]    = miso;
      tick(5);
      sclk_sync = 1'b0;
    end
  endtask

  task automatic csLow();
    cs_n_sync = 1'b0;
    tick(5);
  endtask

  task automatic csHigh();
    tick(5);
    cs_n_sync = 1'b1;
    tick(5);
  endtask

  initial begin
    rst       = 1'b1;
    sclk_sync = 1'b0;
    mosi_sync = 1'b0;
    cs_n_sync = 1'b1;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;

    // 1: reset state, then quiet release with CS idle
    $display("[TB] reset");
    tick(3);
    checkOutput("reset_outputs",
                {26'd0, rx_valid, tx_ready, tx_underrun, frame_abort, cs_active, miso}, 32'd0);
    checkOutput("reset_rx_data", rx_data, 32'h00);
    rst = 1'b0;
    snapshot();
    tick(6);
    checkOutput("idle_pulses",
                rx_cnt - rx_base + ready_cnt - ready_base + underrun_cnt - underrun_base +
                abort_cnt - abort_base, 32'd0);
    checkOutput("idle_cs_active", cs_active, 32'd0);

    // 2: single word, tx word supplied
    $display("[TB] single word A5 / 3C");
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    snapshot();
    csLow();
    checkOutput("f2_tx_ready_at_cs_fall", ready_cnt - ready_base, 32'd1);
    checkOutput("f2_no_underrun", underrun_cnt - underrun_base, 32'd0);
    checkOutput("f2_cs_active", cs_active, 32'd1);
    applyStimulus(8'hA5, 8, miso_word);
    checkOutput("f2_miso_word", miso_word, 32'h3C);
    checkOutput("f2_rx_count", rx_cnt - rx_base, 32'd1);
    checkOutput("f2_rx_value", last_rx, 32'hA5);
    csHigh();
    checkOutput("f2_no_abort", abort_cnt - abort_base, 32'd0);
    checkOutput("f2_cs_active_end", cs_active, 32'd0);
    checkOutput("f2_miso_idle", miso, 32'd0);
    checkOutput("f2_rx_data_held", rx_data, 32'hA5);

    // 3: three words, no tx data ever offered
    $display("[TB] three words, tx underrun");
    tx_valid = 1'b0;
    words[0] = 8'h01;
    words[1] = 8'h80;
    words[2] = 8'hFF;
    snapshot();
    csLow();
    for (int k = 0; k < 3; k++) begin
      tick(2);
      checkOutput($sformatf("f3_underrun_before_w%0d", k), underrun_cnt - underrun_base, k + 1);
      applyStimulus(words[k], 8, miso_word);
      checkOutput($sformatf("f3_miso_w%0d", k), miso_word, 32'hFF);
      checkOutput($sformatf("f3_rx_count_w%0d", k), rx_cnt - rx_base, k + 1);
      checkOutput($sformatf("f3_rx_value_w%0d", k), last_rx, words[k]);
    end
    csHigh();
    checkOutput("f3_no_abort", abort_cnt - abort_base, 32'd0);

    // 4: CS released after 5 bits, then a clean frame
    $display("[TB] abort after 5 bits");
    tx_valid = 1'b1;
    tx_data  = 8'h96;
    snapshot();
    csLow();
    applyStimulus(8'h3E, 5, miso_word);
    checkOutput("f4_partial_miso", miso_word, 32'h90);
    csHigh();
    tick(3);
    checkOutput("f4_abort_single_pulse", abort_cnt - abort_base, 32'd1);
    checkOutput("f4_no_rx", rx_cnt - rx_base, 32'd0);
    checkOutput("f4_rx_data_unchanged", rx_data, 32'hFF);
    snapshot();
    csLow();
    applyStimulus(8'h5A, 8, miso_word);
    csHigh();
    checkOutput("f4_next_rx_count", rx_cnt - rx_base, 32'd1);
    checkOutput("f4_next_rx_data", rx_data, 32'h5A);

    // 5: CS rises in the same cycle as the 8th SCLK rise
    $display("[TB] cs rise on 8th edge");
    snapshot();
    csLow();
    applyStimulus(8'hE7, 7, miso_word);
    mosi_sync = 1'b1;
    tick(5);
    sclk_sync = 1'b1;
    cs_n_sync = 1'b1;
    tick(5);
    sclk_sync = 1'b0;
    tick(5);
    checkOutput("f5_no_rx", rx_cnt - rx_base, 32'd0);
    checkOutput("f5_abort", abort_cnt - abort_base, 32'd1);
    checkOutput("f5_rx_data_unchanged", rx_data, 32'h5A);

    // 6: reset mid-frame with CS held low
    $display("[TB] reset mid-frame");
    snapshot();
    csLow();
    applyStimulus(8'hF0, 4, miso_word);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("f6_cs_active_after_rst", cs_active, 32'd0);
    checkOutput("f6_miso_after_rst", miso, 32'd0);
    checkOutput("f6_rx_data_after_rst", rx_data, 32'h00);
    applyStimulus(8'h0F, 4, miso_word);
    tick(3);
    checkOutput("f6_no_rx_while_cs_low", rx_cnt - rx_base, 32'd0);
    checkOutput("f6_still_idle", cs_active, 32'd0);
    cs_n_sync = 1'b1;
    tick(2);
    csLow();
    applyStimulus(8'hC3, 8, miso_word);
    csHigh();
    checkOutput("f6_rx_count", rx_cnt - rx_base, 32'd1);
    checkOutput("f6_rx_data", rx_data, 32'hC3);
    checkOutput("f6_no_abort", abort_cnt - abort_base, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
